// File: rtl/sent_tx_pulse_gen.sv
// SENT transmit pulse generator.
// Turns one symbol request (data nibble, sync or pause) into one SENT line
// pulse. Each pulse is a LOW_TICKS-tick low phase followed by a high phase.
// The whole symbol lasts N ticks, and each tick is TICK_DIV clk_tx cycles.
// Optional feature macro: SENT_TX_PAUSE_EN. When it is defined, kind 10
// produces a pause pulse whose length is clamped to 12..768 ticks. When it
// is undefined, kind 10 is rejected in the same way as kind 11.
//
// state  | meaning
// S_IDLE | line idles high, ready for a symbol
// S_LOW  | low phase of the current symbol
// S_HIGH | high phase, runs until the tick counter reaches N
module sent_tx_pulse_gen #(
    parameter int TICK_DIV  = 4,
    parameter int LOW_TICKS = 5
) (
    input  logic       clk_tx,
    input  logic       reset_tx,
    input  logic       valid_i,
    input  logic [1:0] kind_i,
    input  logic [3:0] nibble_i,
    input  logic [9:0] pause_len_i,
    output logic       ready_o,
    output logic       data_pulse_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [9:0]    r_tick_cnt;
    logic [9:0]    r_len;
    logic          r_pulse;
    logic          r_err;

    logic          w_tick;
    logic          w_last;
    logic          w_accept;
    logic          w_legal;
    logic [9:0]    w_len;
    logic [9:0]    w_pause_len;
    logic          w_pause_en;

`ifdef SENT_TX_PAUSE_EN
    assign w_pause_en = 1'b1;

    // Clamp the requested pause length to the legal range of 12..768 ticks.
    always_comb begin
        w_pause_len = pause_len_i;
        if (pause_len_i < 10'd12)
            w_pause_len = 10'd12;
        else if (pause_len_i > 10'd768)
            w_pause_len = 10'd768;
    end
`else
    logic w_unused_pause;

    assign w_pause_en     = 1'b0;
    assign w_pause_len    = 10'd0;
    assign w_unused_pause = ^pause_len_i;
`endif

    // The final clock of a symbol: the last tick of the high phase.
    assign w_tick   = (r_presc == PW'(TICK_DIV - 1));
    assign w_last   = (r_state == S_HIGH) && w_tick && (r_tick_cnt == r_len - 10'd1);
    assign ready_o  = (r_state == S_IDLE) || w_last;
    assign w_accept = valid_i && ready_o;

    assign data_pulse_o = r_pulse;
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = w_last;
    assign err_o        = r_err;

    // Decode the symbol length in ticks and whether the requested kind is legal.
    always_comb begin
        w_len   = 10'd0;
        w_legal = 1'b0;
        case (kind_i)
            2'b00: begin
                w_len   = 10'd12 + {6'd0, nibble_i};
                w_legal = 1'b1;
            end
            2'b01: begin
                w_len   = 10'd56;
                w_legal = 1'b1;
            end
            2'b10: begin
                w_len   = w_pause_len;
                w_legal = w_pause_en;
            end
            default: begin
                w_len   = 10'd0;
                w_legal = 1'b0;
            end
        endcase
    end

    // Symbol sequencer: accept a symbol, run the prescaler and tick counter,
    // and step the FSM through LOW and HIGH.
    always_ff @(posedge clk_tx) begin
        if (reset_tx) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_tick_cnt <= '0;
            r_len      <= '0;
            r_pulse    <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_state    <= S_LOW;
                r_len      <= w_len;
                r_presc    <= '0;
                r_tick_cnt <= '0;
                r_pulse    <= 1'b0;
            end else if (w_last) begin
                // No legal follow-on symbol was accepted, so drop back to idle.
                r_state    <= S_IDLE;
                r_presc    <= '0;
                r_tick_cnt <= '0;
                r_pulse    <= 1'b1;
            end else if (r_state != S_IDLE) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if (w_tick) begin
                    r_tick_cnt <= r_tick_cnt + 10'd1;
                    if (r_state == S_LOW && r_tick_cnt == 10'(LOW_TICKS - 1)) begin
                        r_state <= S_HIGH;
                        r_pulse <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
// Self-checking bench for sent_tx_pulse_gen (TICK_DIV=4, LOW_TICKS=5).
// Directed vectors measure whole-symbol timing. A random phase is compared
// cycle by cycle against a symbol-timeline reference model.
module tb_sent_tx_pulse_gen;

    localparam int TD = 4;
    localparam int LT = 5;

    logic       clk_tx = 1'b0;
    logic       reset_tx;
    logic       valid_i;
    logic [1:0] kind_i;
    logic [3:0] nibble_i;
    logic [9:0] pause_len_i;
    logic       ready_o;
    logic       data_pulse_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    int total = 0;
    int bad   = 0;

    sent_tx_pulse_gen #(.TICK_DIV(TD), .LOW_TICKS(LT)) dut (
        .clk_tx       (clk_tx),
        .reset_tx     (reset_tx),
        .valid_i      (valid_i),
        .kind_i       (kind_i),
        .nibble_i     (nibble_i),
        .pause_len_i  (pause_len_i),
        .ready_o      (ready_o),
        .data_pulse_o (data_pulse_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_tx = ~clk_tx;

    typedef struct {
        string      name;
        logic [1:0] kind;
        logic [3:0] nib;
        logic [9:0] plen;
        bit         exp_err;
        int         exp_clk;
        int         exp_low;
    } vec_t;

    vec_t vecs[9];

`ifdef SENT_TX_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    task automatic step();
        @(posedge clk_tx);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Symbol length in ticks, computed directly from the symbol rules.
    function automatic int sym_ticks(input logic [1:0] k, input logic [3:0] n, input logic [9:0] p);
        int v;
        if (k == 2'b00) return 12 + int'(n);
        if (k == 2'b01) return 56;
        v = int'(p);
        if (v < 12)  v = 12;
        if (v > 768) v = 768;
        return v;
    endfunction

    task automatic do_reset();
        reset_tx = 1'b1;
        valid_i  = 1'b0;
        step();
        step();
        reset_tx = 1'b0;
    endtask

    // Apply one symbol from idle and measure its length and low time.
    task automatic run_vec(input vec_t v);
        int lows;
        int done_at;
        valid_i     = 1'b1;
        kind_i      = v.kind;
        nibble_i    = v.nib;
        pause_len_i = v.plen;
        step();
        valid_i     = 1'b0;
        kind_i      = 2'($urandom);
        nibble_i    = 4'($urandom);
        pause_len_i = 10'($urandom);
        if (v.exp_err) begin
            check({v.name, "_err"}, err_o, 1);
            check({v.name, "_line"}, data_pulse_o, 1);
            check({v.name, "_ready"}, ready_o, 1);
            check({v.name, "_busy"}, busy_o, 0);
            step();
            check({v.name, "_err_once"}, err_o, 0);
        end else begin
            lows    = 0;
            done_at = 0;
            for (int c = 1; c <= 4000 && done_at == 0; c++) begin
                if (!data_pulse_o) lows++;
                if (done_o) done_at = c;
                else step();
            end
            check({v.name, "_clocks"}, done_at, v.exp_clk);
            check({v.name, "_low"}, lows, v.exp_low);
            step();
            check({v.name, "_idle_busy"}, busy_o, 0);
            check({v.name, "_idle_line"}, data_pulse_o, 1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, low2, nerr, act, ndone;
        bit m_active, m_err, acc, legal, rst;
        int m_k, m_n;
        bit e_pulse, e_done, e_ready;

        vecs[0] = '{"data0",   2'b00, 4'h0, 10'd0,    1'b0,      48,   20};
        vecs[1] = '{"dataF",   2'b00, 4'hF, 10'd0,    1'b0,      108,  20};
        vecs[2] = '{"data7",   2'b00, 4'h7, 10'd0,    1'b0,      76,   20};
        vecs[3] = '{"sync",    2'b01, 4'h0, 10'd0,    1'b0,      224,  20};
        vecs[4] = '{"pause5",  2'b10, 4'h0, 10'd5,    !PAUSE_EN, 48,   20};
        vecs[5] = '{"pause1k", 2'b10, 4'h0, 10'd1000, !PAUSE_EN, 3072, 20};
        vecs[6] = '{"pause300",2'b10, 4'h0, 10'd300,  !PAUSE_EN, 1200, 20};
        vecs[7] = '{"pause768",2'b10, 4'h0, 10'd768,  !PAUSE_EN, 3072, 20};
        vecs[8] = '{"illegal", 2'b11, 4'h0, 10'd0,    1'b1,      0,    0};

        valid_i     = 1'b0;
        kind_i      = 2'b00;
        nibble_i    = 4'h0;
        pause_len_i = 10'd0;
        do_reset();

        check("rst_line",  data_pulse_o, 1);
        check("rst_ready", ready_o, 1);
        check("rst_busy",  busy_o, 0);
        check("rst_done",  done_o, 0);
        check("rst_err",   err_o, 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Data F then sync back to back with valid held throughout.
        valid_i  = 1'b1;
        kind_i   = 2'b00;
        nibble_i = 4'hF;
        d1 = 0; d2 = 0; low2 = 0;
        for (int c = 1; c <= 400 && d2 == 0; c++) begin
            step();
            if (c == 1) kind_i = 2'b01;
            if (c == 109) check("b2b_no_gap", data_pulse_o, 0);
            if (c > 108 && !data_pulse_o) low2++;
            if (done_o) begin
                if (d1 == 0) d1 = c;
                else d2 = c;
            end
        end
        valid_i = 1'b0;
        check("b2b_done1", d1, 108);
        check("b2b_done2", d2, 332);
        check("b2b_low2",  low2, 20);
        step();
        check("b2b_idle", busy_o, 0);

        // Reset in clock 10 of a sync symbol, then a nibble 3 symbol.
        valid_i = 1'b1;
        kind_i  = 2'b01;
        step();
        valid_i = 1'b0;
        for (int c = 2; c <= 10; c++) step();
        reset_tx = 1'b1;
        step();
        reset_tx = 1'b0;
        check("abort_line",  data_pulse_o, 1);
        check("abort_busy",  busy_o, 0);
        check("abort_done",  done_o, 0);
        check("abort_ready", ready_o, 1);
        ndone = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (done_o) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_vec('{"after_abort", 2'b00, 4'h3, 10'd0, 1'b0, 60, 20});

        // Illegal kind held for three cycles.
        valid_i = 1'b1;
        kind_i  = 2'b11;
        nerr = 0; act = 0;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 3) valid_i = 1'b0;
            if (err_o) nerr++;
            if (!data_pulse_o || busy_o) act++;
        end
        check("ill3_err_count", nerr, 3);
        check("ill3_line_act",  act, 0);

        // Random phase against the symbol-timeline model.
        do_reset();
        m_active = 1'b0; m_err = 1'b0; m_k = 0; m_n = 0;
        for (int cyc = 0; cyc < 15000; cyc++) begin
            e_done  = m_active && (m_k == m_n * TD);
            e_pulse = m_active ? (m_k > LT * TD) : 1'b1;
            e_ready = !m_active || e_done;
            check("rnd_line",  data_pulse_o, int'(e_pulse));
            check("rnd_done",  done_o,  int'(e_done));
            check("rnd_ready", ready_o, int'(e_ready));
            check("rnd_busy",  busy_o,  int'(m_active));
            check("rnd_err",   err_o,   int'(m_err));

            rst         = ($urandom_range(0, 399) == 0);
            reset_tx    = rst;
            valid_i     = ($urandom_range(0, 2) == 0);
            kind_i      = 2'($urandom);
            nibble_i    = 4'($urandom);
            pause_len_i = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 40));

            acc   = valid_i && e_ready;
            legal = (kind_i == 2'b00) || (kind_i == 2'b01) || (PAUSE_EN && kind_i == 2'b10);
            if (rst) begin
                m_active = 1'b0; m_err = 1'b0;
            end else begin
                m_err = acc && !legal;
                if (acc && legal) begin
                    m_active = 1'b1;
                    m_k      = 1;
                    m_n      = sym_ticks(kind_i, nibble_i, pause_len_i);
                end else if (m_active) begin
                    if (e_done) m_active = 1'b0;
                    else m_k++;
                end
            end
            step();
        end
        reset_tx = 1'b0;
        valid_i  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
